// File: rtl/mem_dbus_ctrl.sv
// mem_dbus_ctrl: MEM-stage data-bus master; runs one load/store on the SRAM-like bus and stalls until it completes.
// Optional misalignment exceptions are enabled with `define DBUS_ALIGN_CHECK_EN.
module mem_dbus_ctrl #(
    parameter logic [31:0] ADDR_MASK = 32'h1FFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m_en,
    input  logic [3:0]  m_wen,
    input  logic [31:0] m_vaddr,
    input  logic [31:0] m_wdata,
    input  logic        stall_in,
    input  logic        flush,
    output logic        stallreq,
    output logic [31:0] m_rdata,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic        dbus_req,
    output logic [3:0]  dbus_wen,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_addr_ok,
    input  logic        dbus_data_ok,
    input  logic [31:0] dbus_rdata
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DROP} state_t;
    state_t      r_state, w_next;
    logic        r_drop;
    logic [31:0] r_rdata, r_addr, r_wdata;
    logic [3:0]  r_wen;
    logic        w_issue, w_done_data;
`ifdef DBUS_ALIGN_CHECK_EN
    assign exc_adel = r_state == IDLE && m_en && m_wen == 4'b0000 && m_vaddr[1:0] != 2'b00;
    assign exc_ades = r_state == IDLE && m_en &&
                      ((m_wen == 4'b1111 && m_vaddr[1:0] != 2'b00) ||
                       ((m_wen == 4'b0011 || m_wen == 4'b1100) && m_vaddr[0]));
`else
    assign exc_adel = 1'b0;
    assign exc_ades = 1'b0;
`endif
    // rst gates the combinational issue so nothing leaks onto the bus during reset
    assign w_issue     = r_state == IDLE && m_en && !flush && !exc_adel && !exc_ades && !rst;
    assign w_done_data = r_state == WAIT && dbus_data_ok && !flush;
    always_comb begin
        w_next     = r_state;
        dbus_req   = 1'b0;
        dbus_addr  = r_addr;
        dbus_wen   = r_wen;
        dbus_wdata = r_wdata;
        m_rdata    = r_rdata;
        stallreq   = 1'b0;
        case (r_state)
            IDLE: begin
                dbus_req   = w_issue;
                dbus_addr  = m_vaddr & ADDR_MASK;
                dbus_wen   = m_wen;
                dbus_wdata = m_wdata;
                stallreq   = w_issue;
                w_next     = w_issue ? (dbus_addr_ok ? WAIT : REQ) : IDLE;
            end
            REQ: begin
                dbus_req = 1'b1;
                stallreq = m_en;
                w_next   = dbus_addr_ok ? ((r_drop || flush) ? DROP : WAIT) : REQ;
            end
            WAIT: begin
                stallreq = m_en && !flush && !dbus_data_ok;
                m_rdata  = w_done_data ? dbus_rdata : r_rdata;
                w_next   = dbus_data_ok ? (w_done_data && stall_in ? DONE : IDLE) : (flush ? DROP : WAIT);
            end
            DONE: w_next = (!stall_in || flush) ? IDLE : DONE;
            DROP: begin
                stallreq = m_en;
                w_next   = dbus_data_ok ? IDLE : DROP;
            end
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_drop  <= 1'b0;
            r_rdata <= '0;
            r_addr  <= '0;
            r_wen   <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_issue) begin
                r_drop  <= 1'b0;
                r_addr  <= m_vaddr & ADDR_MASK;
                r_wen   <= m_wen;
                r_wdata <= m_wdata;
            end else if (r_state == REQ && flush) begin
                r_drop <= 1'b1;
            end
            if (w_done_data) r_rdata <= dbus_rdata;
        end
    end
endmodule
